// File: rtl/uart_tx_stream.sv
// uart_tx_stream: UART transmitter fed by a valid/ready byte stream.
// Frame is LSB first: start (0), DATA_BITS data bits, optional parity,
// then STOP_BITS stop bits (1). A word accepted in the last cycle of the
// final stop bit starts the next frame with no idle gap.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   data   payload, sampled only on the accept edge
//   valid  producer has a word on data
//   ready  transmitter can accept a word this cycle (combinational)
//   tx     serial line, idle high, registered
//   busy   a frame is in progress
module uart_tx_stream #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  // Reject illegal configurations at elaboration time.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_stream: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_stream: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q;
  logic [BaudW-1:0]     baud_q;
  logic [BitW-1:0]      bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_q;

  logic baud_wrap;
  logic last_stop;
  logic accept;
  logic par_bit;

  always_comb begin
    baud_wrap = (baud_q == BaudLast);
    // Final cycle of the final stop bit: the only point a busy frame can take a new word.
    last_stop = (state_q == StStop) && (bit_q == StopLast) && baud_wrap;
    ready     = rst_n && ((state_q == StIdle) || last_stop);
    accept    = valid && ready;
    // Odd parity makes the total count of ones odd, even makes it even.
    par_bit   = (PARITY == 1) ? ~^data : ^data;
    busy      = (state_q != StIdle);
    tx        = tx_q;
  end

  // tx is computed alongside the state transition so it changes on the
  // same edge the FSM enters the corresponding bit period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (accept) begin
      state_q <= StStart;
      tx_q    <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= data;
      par_q   <= par_bit;
    end else if (state_q == StIdle) begin
      tx_q    <= 1'b1;
      baud_q  <= '0;
    end else if (!baud_wrap) begin
      baud_q  <= baud_q + 1'b1;
    end else begin
      // Bit boundary.
      baud_q <= '0;
      unique case (state_q)
        StStart: begin
          state_q <= StData;
          tx_q    <= shift_q[0];
          bit_q   <= '0;
        end
        StData: begin
          if (bit_q == DataLast) begin
            bit_q <= '0;
            if (PARITY != 0) begin
              state_q <= StParity;
              tx_q    <= par_q;
            end else begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_q   <= bit_q + 1'b1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
        StParity: begin
          state_q <= StStop;
          tx_q    <= 1'b1;
          bit_q   <= '0;
        end
        StStop: begin
          tx_q <= 1'b1;
          if (bit_q == StopLast) begin
            state_q <= StIdle;
            bit_q   <= '0;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          bit_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: six configurations run in parallel, each with a
// cycle-level frame timeline model and an independent mid-bit sampling receiver.
module tb_uart_tx_stream;

  localparam int NCfg = 6;

  function automatic int unsigned cfg_cpb(input int i);
    case (i)
      0, 1, 2: return 4;
      3:       return 3;
      4:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned cfg_db(input int i);
    case (i)
      3:       return 7;
      5:       return 9;
      default: return 8;
    endcase
  endfunction

  // 0 none, 1 odd, 2 even
  function automatic int unsigned cfg_par(input int i);
    case (i)
      1:       return 2;
      2:       return 1;
      5:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned cfg_sb(input int i);
    case (i)
      3, 5:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned cfg_w1(input int i);
    case (i)
      0:       return 32'h48;
      1, 2:    return 32'h07;
      3:       return 32'h55;
      4:       return 32'hA5;
      default: return 32'h1A5;
    endcase
  endfunction

  function automatic int unsigned cfg_w2(input int i);
    case (i)
      3:       return 32'h2A;
      default: return 32'h3C;
    endcase
  endfunction

  logic clk;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCfg; gi++) begin : g_cfg
    localparam int unsigned CPB   = cfg_cpb(gi);
    localparam int unsigned DB    = cfg_db(gi);
    localparam int unsigned PAR   = cfg_par(gi);
    localparam int unsigned SB    = cfg_sb(gi);
    localparam int unsigned NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int unsigned FRAME = NBITS * CPB;

    logic          rst_n;
    logic          valid;
    logic [DB-1:0] data;
    logic          ready;
    logic          tx;
    logic          busy;

    uart_tx_stream #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY      (PAR),
      .STOP_BITS   (SB)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .data (data),
      .valid(valid),
      .ready(ready),
      .tx   (tx),
      .busy (busy)
    );

    // Timeline model: when busy, m_off counts cycles since the accept edge.
    bit            m_busy = 1'b0;
    int            m_off = 0;
    logic [15:0]   m_bits = '1;
    int            cyc = 0;
    int            gen = 0;
    int            n_acc = 0;
    int            n_sent = 0;
    int            n_rx = 0;
    int            fall_prev = 0;
    int            fall_last = 0;
    logic [DB-1:0] exp_q[$];

    // Expected line levels per bit period, straight from the frame format.
    function automatic logic [15:0] frame_of(input logic [DB-1:0] d);
      logic [15:0] f;
      int          ones;
      f    = '1;
      f[0] = 1'b0;
      for (int j = 0; j < int'(DB); j++) f[1+j] = d[j];
      ones = $countones(d);
      if (PAR == 1) f[1+DB] = ((ones % 2) == 0);
      if (PAR == 2) f[1+DB] = ((ones % 2) == 1);
      return f;
    endfunction

    task automatic step(input logic r, input logic v, input logic [DB-1:0] d);
      logic er;
      @(negedge clk);
      rst_n = r;
      valid = v;
      data  = d;
      #1;
      er = r && (!m_busy || m_off == int'(FRAME) - 1);
      check_eq($sformatf("c%0d tx", gi), tx, m_busy ? m_bits[m_off/CPB] : 1'b1);
      check_eq($sformatf("c%0d busy", gi), busy, m_busy);
      check_eq($sformatf("c%0d ready", gi), ready, er);
      if (!r) begin
        if (m_busy) begin
          void'(exp_q.pop_back());
          n_sent--;
        end
        gen++;
        m_busy = 1'b0;
      end else if (v && er) begin
        m_busy = 1'b1;
        m_off  = 0;
        m_bits = frame_of(d);
        exp_q.push_back(d);
        n_acc++;
        n_sent++;
      end else if (m_busy) begin
        if (m_off == int'(FRAME) - 1) m_busy = 1'b0;
        else m_off++;
      end
      @(posedge clk);
      cyc++;
    endtask

    // Reference receiver: finds the start edge and samples each bit mid-period.
    initial begin : rx
      int            g0;
      logic [DB-1:0] d;
      logic          s;
      logic          p;
      logic          exp_p;
      logic [DB-1:0] e;
      forever begin
        @(negedge clk);
        if (tx === 1'b0) begin
          g0        = gen;
          fall_prev = fall_last;
          fall_last = cyc;
          repeat (CPB / 2) @(negedge clk);
          s = tx;
          for (int j = 0; j < int'(DB); j++) begin
            repeat (CPB) @(negedge clk);
            d[j] = tx;
          end
          // Bit after the data: parity if enabled, otherwise the first stop bit.
          repeat (CPB) @(negedge clk);
          p = tx;
          if (g0 == gen) begin
            exp_p = (PAR == 0) ? 1'b1 :
                    (PAR == 1) ? (($countones(d) % 2) == 0) : (($countones(d) % 2) == 1);
            check_eq($sformatf("c%0d rx start", gi), s, 1'b0);
            check_eq($sformatf("c%0d rx par", gi), p, exp_p);
          end
          for (int k = 0; k < int'(NBITS) - 2 - int'(DB); k++) begin
            repeat (CPB) @(negedge clk);
            if (g0 == gen) check_eq($sformatf("c%0d rx stop", gi), tx, 1'b1);
          end
          if (g0 == gen) begin
            check_eq($sformatf("c%0d rx pending", gi), exp_q.size() != 0, 1'b1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check_eq($sformatf("c%0d rx data", gi), d, e);
            n_rx++;
          end
        end
      end
    end

    initial begin : stim
      int            k0;
      logic [DB-1:0] w1;
      logic [DB-1:0] w2;
      w1 = DB'(cfg_w1(gi));
      w2 = DB'(cfg_w2(gi));

      // Reset held with valid high: no accept, line idle.
      rst_n = 1'b0;
      valid = 1'b1;
      data  = w1;
      @(posedge clk);
      repeat (3) step(1'b0, 1'b1, w1);
      step(1'b1, 1'b0, '0);

      // Single directed frame, data wiggling afterwards.
      step(1'b1, 1'b1, w1);
      repeat (FRAME + 2) step(1'b1, 1'b0, DB'($urandom));

      // Back-to-back pair with valid held high.
      k0 = n_acc;
      for (int c = 0; c < 3 * int'(FRAME) && n_acc - k0 < 2; c++)
        step(1'b1, 1'b1, (n_acc == k0) ? w1 : w2);
      check_eq($sformatf("c%0d b2b accepts", gi), n_acc - k0, 2);
      repeat (FRAME + 4) step(1'b1, 1'b0, '0);
      check_eq($sformatf("c%0d b2b gap", gi), fall_last - fall_prev, FRAME);

      // Reset in the middle of data bit 3, then a clean frame.
      step(1'b1, 1'b1, DB'($urandom));
      repeat (4 * CPB + CPB / 2) step(1'b1, 1'b0, DB'($urandom));
      step(1'b0, 1'b1, DB'($urandom));
      repeat (FRAME + 2) step(1'b1, 1'b0, DB'($urandom));
      step(1'b1, 1'b1, DB'(32'hA5));
      repeat (FRAME + 2) step(1'b1, 1'b0, '0);

      // Random valid with data changing every cycle.
      k0 = n_acc;
      for (int c = 0; c < 256 * 2 * int'(FRAME) && n_acc - k0 < 256; c++)
        step(1'b1, $urandom_range(0, 3) != 0, DB'($urandom));
      check_eq($sformatf("c%0d random accepts", gi), n_acc - k0, 256);
      repeat (2 * FRAME) step(1'b1, 1'b0, '0);

      check_eq($sformatf("c%0d rx count", gi), n_rx, n_sent);
      check_eq($sformatf("c%0d rx leftover", gi), exp_q.size(), 0);
      n_done++;
    end
  end

  initial begin : main
    for (int c = 0; c < 60000 && n_done < NCfg; c++) @(posedge clk);
    check_eq("all configs done", n_done, NCfg);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
